// File: rtl/mem_seq_pkg.sv
// Shared encodings and defaults for the reg_data_mem block sequencer.
package mem_seq_pkg;

    localparam int AW      = 4;
    localparam int DW      = 16;
    localparam int LW      = 5;
    localparam int MAX_LEN = 16;

    typedef enum logic [1:0] {
        OP_FILL = 2'b00,
        OP_DUMP = 2'b01,
        OP_COPY = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_DUMP_RD,
        S_DUMP_OUT,
        S_COPY_RD,
        S_COPY_WR,
        S_DONE,
        S_ERR
    } state_e;

endpackage

// File: rtl/mem_seq_master.sv
// Block-command initiator for reg_data_mem: FILL, DUMP (valid/ready stream) and COPY,
// sequencing addr/data_in/MemWrite/MemRead one access per cycle.
//
// state      | meaning
// S_IDLE     | cmd_ready high, waiting for a command
// S_FILL     | write seed+i to dst+i, one word per cycle
// S_DUMP_RD  | read src+i, capture into rd_data
// S_DUMP_OUT | hold rd_data/rd_valid until rd_ready
// S_COPY_RD  | read src+i into the word latch
// S_COPY_WR  | write the latched word to dst+i
// S_DONE     | one-cycle done pulse
// S_ERR      | one-cycle err pulse (reserved op or len too large)
module mem_seq_master
    import mem_seq_pkg::*;
#(
    parameter int AW = mem_seq_pkg::AW,
    parameter int DW = mem_seq_pkg::DW,
    parameter int LW = mem_seq_pkg::LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_src,
    input  logic [AW-1:0] cmd_dst,
    input  logic [LW-1:0] cmd_len,
    input  logic [DW-1:0] cmd_seed,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          MemWrite,
    output logic          MemRead
);

    localparam logic [LW-1:0] LEN_MAX = LW'(2**AW);

    state_e        state_q, state_d;
    logic [AW-1:0] src_q, dst_q;
    logic [LW-1:0] len_q, idx_q;
    logic [DW-1:0] seed_q, word_q;
    logic [AW-1:0] off;
    logic          last;
    logic          adv;

    assign off  = idx_q[AW-1:0];
    assign last = (idx_q == len_q - LW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        adv       = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (op_e'(cmd_op) == OP_RSVD || cmd_len > LEN_MAX) state_d = S_ERR;
                    else if (cmd_len == '0)                           state_d = S_DONE;
                    else begin
                        case (op_e'(cmd_op))
                            OP_FILL: state_d = S_FILL;
                            OP_DUMP: state_d = S_DUMP_RD;
                            OP_COPY: state_d = S_COPY_RD;
                            default: state_d = S_ERR;
                        endcase
                    end
                end
            end
            S_FILL: begin
                MemWrite  = 1'b1;
                mem_addr  = dst_q + off;
                mem_wdata = seed_q + DW'(idx_q);
                if (last) state_d = S_DONE;
                else      adv = 1'b1;
            end
            S_DUMP_RD: begin
                MemRead  = 1'b1;
                mem_addr = src_q + off;
                state_d  = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (rd_ready) begin
                    if (last) state_d = S_DONE;
                    else begin
                        adv     = 1'b1;
                        state_d = S_DUMP_RD;
                    end
                end
            end
            S_COPY_RD: begin
                MemRead  = 1'b1;
                mem_addr = src_q + off;
                state_d  = S_COPY_WR;
            end
            S_COPY_WR: begin
                MemWrite  = 1'b1;
                mem_addr  = dst_q + off;
                mem_wdata = word_q;
                if (last) state_d = S_DONE;
                else begin
                    adv     = 1'b1;
                    state_d = S_COPY_RD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command fields are only sampled on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            seed_q   <= '0;
            idx_q    <= '0;
            word_q   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                src_q  <= cmd_src;
                dst_q  <= cmd_dst;
                len_q  <= cmd_len;
                seed_q <= cmd_seed;
                idx_q  <= '0;
            end
            if (adv) idx_q <= idx_q + LW'(1);
            if (state_q == S_DUMP_RD) begin
                rd_data  <= mem_rdata;
                rd_valid <= 1'b1;
            end
            if (state_q == S_DUMP_OUT && rd_ready) rd_valid <= 1'b0;
            if (state_q == S_COPY_RD) word_q <= mem_rdata;
        end
    end

endmodule

// File: doc/mem_seq_master.md
Name: mem_seq_master

Overview:
Initiator for the 16x16 register data memory (reg_data_mem). It accepts one block command at a time and drives the memory's addr/data_in/MemWrite/MemRead pins cycle by cycle. Commands are FILL (write an incrementing pattern), DUMP (read words out through a valid/ready stream) and COPY (memory-to-memory move). It sits between the control path or test harness and reg_data_mem, replacing hand-sequenced MemWrite/MemRead strobes.

Parameters:
AW, 4, memory address width (depth 2**AW = 16)
DW, 16, data word width
LW, 5, length field width (must hold 2**AW)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted on a clk edge with cmd_valid & cmd_ready
cmd_op  in  2  00 FILL, 01 DUMP, 10 COPY, 11 reserved
cmd_src  in  AW  source base address (DUMP, COPY)
cmd_dst  in  AW  destination base address (FILL, COPY)
cmd_len  in  LW  word count, 0..16
cmd_seed  in  DW  first FILL value
rd_data  out  DW  DUMP stream data (registered)
rd_valid  out  1  DUMP stream valid
rd_ready  in  1  DUMP stream ready
done  out  1  one-cycle pulse: command completed
err  out  1  one-cycle pulse: command rejected
mem_addr  out  AW  to reg_data_mem addr
mem_wdata  out  DW  to reg_data_mem data_in
mem_rdata  in  DW  from reg_data_mem data_out
MemWrite  out  1  to reg_data_mem MemWrite
MemRead  out  1  to reg_data_mem MemRead

Behaviour:
- Memory contract: write occurs on the rising clk edge while MemWrite=1; read is combinational, mem_rdata valid in the same cycle MemRead=1, captured by this block on the next edge.
- Reset: state IDLE, cmd_ready=1 after reset releases; rd_valid, done, err, MemWrite, MemRead=0; mem_addr, mem_wdata, rd_data=0. Reset mid-command aborts it immediately: no done, no further memory strobes, partial writes remain in memory.
- Command fields are latched at acceptance; later changes on cmd_* are ignored.
- Offset counter i runs 0..len-1; addresses are (base+i) mod 16, i.e. wrap 15 -> 0.
- States: IDLE, FILL, DUMP_RD, DUMP_OUT, COPY_RD, COPY_WR, DONE, ERR.
- IDLE: on acceptance -> ERR if op=11 or len>16; -> DONE if len=0 (no memory access); else -> FILL / DUMP_RD / COPY_RD.
- FILL: one word per cycle: MemWrite=1, mem_addr=dst+i, mem_wdata=seed+i (mod 2**DW). After word len-1 -> DONE. Latency: accept edge, then len write cycles, done in cycle len+1.
- DUMP_RD: MemRead=1, mem_addr=src+i; rd_data<=mem_rdata, rd_valid<=1 at the edge -> DUMP_OUT.
- DUMP_OUT: MemRead=0, rd_data and rd_valid held stable until rd_ready=1; on handshake edge rd_valid<=0, -> DUMP_RD (next i) or DONE after last. Throughput 2 cycles/word at best.
- COPY_RD: MemRead=1, mem_addr=src+i, word latched -> COPY_WR. COPY_WR: MemWrite=1, mem_addr=dst+i, mem_wdata=latched word -> COPY_RD or DONE. Copy is strictly ascending; overlapping ranges with dst>src propagate already-written words (defined behaviour, not an error).
- DONE / ERR: one cycle, done or err pulses, -> IDLE. done and err are never high together.
- MemWrite and MemRead are never both 1; both 0 in IDLE, DONE, ERR, DUMP_OUT.
- cmd_ready=0 in every state except IDLE; back-to-back commands therefore have at least one idle cycle of gap (the DONE cycle).

Decomposition:
- Package mem_seq_pkg: op encodings (OP_FILL, OP_DUMP, OP_COPY, OP_RSVD), state enum, AW/DW/LW defaults, MAX_LEN=16.
- No sub-module; a single FSM plus offset counter and word latch. The bench instantiates mem_seq_master driving a real reg_data_mem.

Test Plan:
- FILL dst=14 len=4 seed=16'h0100 -> writes addr 14,15,0,1 with 0100..0103 in 4 consecutive cycles; done 5 cycles after acceptance; DUMP src=14 len=4 returns 0100,0101,0102,0103.
- DUMP src=5 len=3 with rd_ready low for 3 cycles on word 2 -> rd_data held stable, MemRead=0 while stalled; words arrive in address order; exactly 3 handshakes then done.
- COPY src=0 dst=8 len=8 after FILL seed=1 -> addr 8..15 read back 1..8; MemRead and MemWrite alternate and never overlap; done after 16 access cycles.
- cmd_op=11 or cmd_len=17 -> err pulse one cycle, no MemWrite/MemRead; cmd_len=0 -> done one cycle after acceptance, no memory access.
- rst asserted mid-FILL after 2 of 6 writes -> outputs 0 immediately, no done; only the first 2 addresses modified; next command accepted normally after release.
- cmd_valid held high continuously with changing fields -> cmd_ready low during execution, each command's fields latched only at its own acceptance.
